// File: rtl/reg_file8x16.sv
// reg_file8x16: eight-entry register file, one one-hot write port, two read ports,
// optional same-cycle write forwarding and a sticky multi-hot write-enable flag.
module reg_file8x16 #(
  parameter int WIDTH  = 16,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       we,
  input  logic [WIDTH-1:0] W,
  input  logic [2:0]       R_Adr,
  input  logic [2:0]       S_Adr,
  output logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] S,
  input  logic             clr_err,
  output logic             onehot_err
);
  logic [WIDTH-1:0] regs [8];
  logic             one_hot, multi_hot, hit_r, hit_s;
  logic [2:0]       wa;
  always_comb begin
    multi_hot = (we & (we - 8'd1)) != 8'd0;
    one_hot   = (we != 8'd0) && !multi_hot;
    wa        = 3'd0;
    for (int i = 0; i < 8; i++) wa = we[i] ? 3'(i) : wa;
    // forwarding is masked during reset so the ports read the cleared storage
    hit_r = BYPASS && reset_n && one_hot && (wa == R_Adr);
    hit_s = BYPASS && reset_n && one_hot && (wa == S_Adr);
    R     = hit_r ? W : regs[R_Adr];
    S     = hit_s ? W : regs[S_Adr];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      onehot_err <= 1'b0;
    end else begin
      if (one_hot) regs[wa] <= W;
      if (multi_hot) onehot_err <= 1'b1;
      else if (clr_err) onehot_err <= 1'b0;
    end
endmodule

// File: tb/tb_reg_file8x16.sv
// tb_reg_file8x16: directed test of reg_file8x16 in both forwarding modes against an
// array-based model checked every falling edge, plus hand-computed literal checks.
module tb_reg_file8x16;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  we = 8'h00;
  logic [15:0] W = 16'h0000;
  logic [2:0]  R_Adr = 3'd0, S_Adr = 3'd0;
  logic        clr_err = 1'b0;
  logic [15:0] r1, s1, r0, s0;
  logic        e1, e0;
  int          errors = 0, checks = 0;
  logic [15:0] mdl [8];
  logic        m_err;

  always #5 clk = ~clk;

  reg_file8x16 #(.WIDTH(16), .BYPASS(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .we(we), .W(W), .R_Adr(R_Adr), .S_Adr(S_Adr),
    .R(r1), .S(s1), .clr_err(clr_err), .onehot_err(e1));
  reg_file8x16 #(.WIDTH(16), .BYPASS(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .we(we), .W(W), .R_Adr(R_Adr), .S_Adr(S_Adr),
    .R(r0), .S(s0), .clr_err(clr_err), .onehot_err(e0));

  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) mdl[i] <= 16'h0000;
      m_err <= 1'b0;
    end else begin
      if ($countones(we) == 1) mdl[$clog2(we)] <= W;
      if ($countones(we) >= 2) m_err <= 1'b1;
      else if (clr_err) m_err <= 1'b0;
    end

  function automatic logic [15:0] exp_rd(input logic [2:0] adr, input bit byp);
    return (byp && reset_n && $countones(we) == 1 && we[adr]) ? W : mdl[adr];
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model R byp", r1, exp_rd(R_Adr, 1'b1));
    chk("model S byp", s1, exp_rd(S_Adr, 1'b1));
    chk("model R nobyp", r0, exp_rd(R_Adr, 1'b0));
    chk("model S nobyp", s0, exp_rd(S_Adr, 1'b0));
    chk("model err byp", {15'd0, e1}, {15'd0, m_err});
    chk("model err nobyp", {15'd0, e0}, {15'd0, m_err});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_both(input string nm, input logic [15:0] er, input logic [15:0] es);
    chk({nm, " R byp"}, r1, er);
    chk({nm, " S byp"}, s1, es);
    chk({nm, " R nobyp"}, r0, er);
    chk({nm, " S nobyp"}, s0, es);
  endtask

  task automatic chk_err(input string nm, input logic exp);
    chk({nm, " byp"}, {15'd0, e1}, {15'd0, exp});
    chk({nm, " nobyp"}, {15'd0, e0}, {15'd0, exp});
  endtask

  logic [15:0] final_vals [8] = '{16'h1111, 16'h2222, 16'h3333, 16'hBEEF,
                                  16'h5555, 16'h6666, 16'h7777, 16'h8888};

  initial begin
    #3;
    chk_both("reset read", 16'h0000, 16'h0000);
    chk_err("reset err", 1'b0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      we = 8'(1 << i);
      W  = 16'(16'h1111 * (i + 1));
      step();
    end
    we = 8'h00;
    for (int i = 0; i < 8; i++) begin
      R_Adr = 3'(i);
      S_Adr = 3'(7 - i);
      #1;
      chk_both("sweep", 16'(16'h1111 * (i + 1)), 16'(16'h1111 * (8 - i)));
      step();
    end
    we = 8'h08; W = 16'hBEEF; R_Adr = 3'd3; S_Adr = 3'd3;
    #1;
    chk("bypass R", r1, 16'hBEEF);
    chk("bypass S", s1, 16'hBEEF);
    chk("nobypass R old", r0, 16'h4444);
    chk("nobypass S old", s0, 16'h4444);
    step();
    we = 8'h00;
    #1;
    chk_both("after write", 16'hBEEF, 16'hBEEF);
    we = 8'h21; W = 16'hDEAD; R_Adr = 3'd0; S_Adr = 3'd5;
    #1;
    chk_both("multihot same cycle", 16'h1111, 16'h6666);
    chk_err("err before edge", 1'b0);
    step();
    we = 8'h00;
    #1;
    chk_both("multihot no write", 16'h1111, 16'h6666);
    chk_err("err set", 1'b1);
    repeat (5) step();
    chk_err("err sticky", 1'b1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk_err("err cleared", 1'b0);
    clr_err = 1'b1; we = 8'hC0;
    step();
    clr_err = 1'b0; we = 8'h00;
    chk_err("set beats clear", 1'b1);
    chk_both("0xC0 no write", 16'h1111, 16'h6666);
    we = 8'h00; W = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      R_Adr = 3'(i);
      S_Adr = 3'(7 - i);
      #1;
      chk_both("idle hold", final_vals[i], final_vals[7 - i]);
      chk_err("idle err hold", 1'b1);
      step();
    end
    we = 8'h04; W = 16'h5A5A; R_Adr = 3'd2; S_Adr = 3'd2;
    step();
    we = 8'h00;
    #1;
    chk_both("write 5A5A", 16'h5A5A, 16'h5A5A);
    we = 8'h04; W = 16'h1234;
    #1;
    reset_n = 1'b0;
    #1;
    chk_both("async reset", 16'h0000, 16'h0000);
    chk_err("async reset err", 1'b0);
    step();
    reset_n = 1'b1;
    we = 8'h00;
    #1;
    chk_both("after reset", 16'h0000, 16'h0000);
    chk_err("after reset err", 1'b0);
    we = 8'h04; W = 16'h00FF;
    step();
    we = 8'h00;
    #1;
    chk_both("post reset write", 16'h00FF, 16'h00FF);
    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
